// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master and any SPI slave models.
// Holds the FSM state encoding, the CPOL/CPHA mode pair and the four standard modes.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    TRAIL
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

  // Data is sampled on leading edges for CPHA=0 and on trailing edges for CPHA=1.
  function automatic logic is_sample_edge(spi_mode_t mode, logic leading);
    return leading ^ mode.cpha;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK timebase: one-cycle tick every H = max(div,1) clk cycles while enabled.
// The count restarts from the current divider on every rising edge of en.
module spi_clkgen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;
  logic [DIV_W-1:0] cur;
  logic             en_q;

  assign reload = (div == '0) ? '0 : div - 1'b1;
  // On the first enabled cycle the stale counter is ignored, so the first
  // tick lands exactly H cycles after en rises (immediately when H = 1).
  assign cur    = (en && !en_q) ? reload : cnt;
  assign tick   = en && (cur == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= en;
      if (en) begin
        cnt <= tick ? reload : cur - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Runtime-configurable SPI master: four CPOL/CPHA modes, MSB/LSB-first,
// programmable SCK half-period and one-hot chip selects held across multi-word transactions.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CS = 2,
  parameter  int DIV_W  = 16,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              start,
  input  logic              last,
  input  logic [DATA_W-1:0] tx_data,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int BC_W = $clog2(2 * DATA_W);
  localparam logic [BC_W-1:0] LAST_EDGE = BC_W'(2 * DATA_W - 1);

  state_t            state;
  spi_mode_t         mode_q;
  logic [DIV_W-1:0]  div_q;
  logic              lsb_q;
  logic              last_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BC_W-1:0]   bit_cnt;

  logic tick;
  logic clk_en;
  logic accept;
  logic word_cpha;
  logic toggle;
  logic leading;
  logic final_edge;
  logic sample_now;

  function automatic logic head_bit(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] push_bit(logic [DATA_W-1:0] w, logic b, logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range selects match no line, so the word still runs with every CS high.
  function automatic logic [NUM_CS-1:0] cs_decode(logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] cs;
    cs = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) cs[i] = 1'b0;
    end
    return cs;
  endfunction

  assign ready      = (state == IDLE) || (state == HOLD);
  assign busy       = (state != IDLE);
  assign clk_en     = (state == SETUP) || (state == SHIFT) || (state == TRAIL);
  assign accept     = start && ready;
  // The first word of a transaction uses the live CPHA; later words reuse the latched one.
  assign word_cpha  = (state == IDLE) ? cfg_cpha : mode_q.cpha;
  // The SETUP-closing tick is also the first SCK edge, so CS-low to first edge is exactly H.
  assign toggle     = tick && ((state == SETUP) || (state == SHIFT));
  assign leading    = ~bit_cnt[0];
  assign final_edge = (bit_cnt == LAST_EDGE);
  assign sample_now = is_sample_edge(mode_q, leading);

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en),
    .div   (div_q),
    .tick  (tick)
  );

  // NOTE: every register here is assigned with <= so all of them see pre-edge
  // values; later assignments in this block intentionally override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= MODE0;
      div_q    <= '0;
      lsb_q    <= 1'b0;
      last_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          sck  <= cfg_cpol;
          mosi <= 1'b0;
          cs_n <= '1;
        end
        HOLD: begin
          sck <= mode_q.cpol;
        end
        TRAIL: begin
          sck <= mode_q.cpol;
          if (tick) begin
            cs_n  <= '1;
            state <= IDLE;
          end
        end
        default: ;
      endcase

      if (accept) begin
        div_q   <= cfg_div;
        lsb_q   <= cfg_lsb_first;
        last_q  <= last;
        bit_cnt <= '0;
        state   <= SETUP;
        // CPHA=0 must present the first bit before the first (sampling) edge.
        if (!word_cpha) begin
          mosi  <= head_bit(tx_data, cfg_lsb_first);
          tx_sr <= drop_bit(tx_data, cfg_lsb_first);
        end else begin
          tx_sr <= tx_data;
        end
        if (state == IDLE) begin
          mode_q <= '{cpol: cfg_cpol, cpha: cfg_cpha};
          cs_n   <= cs_decode(cs_sel);
        end
      end

      if (toggle) begin
        sck     <= ~sck;
        bit_cnt <= bit_cnt + 1'b1;
        if (state == SETUP) state <= SHIFT;

        if (sample_now) begin
          rx_sr <= push_bit(rx_sr, miso, lsb_q);
        end else if (!final_edge) begin
          mosi  <= head_bit(tx_sr, lsb_q);
          tx_sr <= drop_bit(tx_sr, lsb_q);
        end

        // For CPHA=1 the final edge is also the last sample, so fold miso in directly.
        if (final_edge) begin
          rx_data  <= mode_q.cpha ? push_bit(rx_sr, miso, lsb_q) : rx_sr;
          rx_valid <= 1'b1;
          state    <= last_q ? TRAIL : HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg with a behavioural SPI slave and rx/mosi scoreboards.
module tb_spi_master_cfg;
  import spi_pkg::*;

  localparam int DATA_W = 8;
  localparam int NUM_CS = 2;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [DIV_W-1:0]  cfg_div;
  logic [0:0]        cs_sel;
  logic              start, last;
  logic [DATA_W-1:0] tx_data;
  logic              ready, busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              sck, mosi, miso;
  logic [NUM_CS-1:0] cs_n;

  always #5 clk = ~clk;

  spi_master_cfg #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_cpol      (cfg_cpol),
    .cfg_cpha      (cfg_cpha),
    .cfg_lsb_first (cfg_lsb_first),
    .cfg_div       (cfg_div),
    .cs_sel        (cs_sel),
    .start         (start),
    .last          (last),
    .tx_data       (tx_data),
    .ready         (ready),
    .busy          (busy),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .sck           (sck),
    .mosi          (mosi),
    .miso          (miso),
    .cs_n          (cs_n)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              lst;
  } exp_t;

  exp_t              exp_rx[$];
  logic [DATA_W-1:0] exp_mosi[$];
  logic [DATA_W-1:0] slave_q[$];
  time               edge_t[$];
  time               t_cs0_fall, t_cs0_rise;
  int                rxv_cnt = 0;
  int                s_words = 0;
  int                cs1_rise = 0;
  int                cs0_fall = 0;

  // Behavioural slave: shifts out slave_q words and reassembles what it sees on mosi.
  spi_mode_t         s_mode;
  logic              s_lsb;
  int                s_edges;
  logic [DATA_W-1:0] s_tx, s_rx;
  logic              cs_act;

  assign cs_act = (cs_n != '1);

  task automatic s_present();
    miso = s_lsb ? s_tx[0] : s_tx[DATA_W-1];
    s_tx = s_lsb ? (s_tx >> 1) : (s_tx << 1);
  endtask

  task automatic s_load();
    if (slave_q.size() > 0) s_tx = slave_q.pop_front();
    else s_tx = '0;
    s_edges = 0;
    s_rx    = '0;
    if (!s_mode.cpha) s_present();
  endtask

  always @(posedge cs_act) s_load();

  always @(sck) begin
    if (cs_act) begin
      edge_t.push_back($time);
      if (is_sample_edge(s_mode, (s_edges % 2) == 0))
        s_rx = s_lsb ? {mosi, s_rx[DATA_W-1:1]} : {s_rx[DATA_W-2:0], mosi};
      else if (s_edges != 2 * DATA_W - 1)
        s_present();
      s_edges++;
      if (s_edges == 2 * DATA_W) begin
        s_words++;
        if (exp_mosi.size() > 0) check("mosi_word", 32'(s_rx), 32'(exp_mosi.pop_front()));
        s_load();
      end
    end
  end

  always @(negedge cs_n[0]) begin
    t_cs0_fall = $time;
    cs0_fall++;
  end
  always @(posedge cs_n[0]) t_cs0_rise = $time;
  always @(posedge cs_n[1]) cs1_rise++;

  always @(negedge clk) begin : rx_mon
    exp_t e;
    if (rx_valid) begin
      rxv_cnt++;
      if (exp_rx.size() > 0) begin
        e = exp_rx.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("ready_with_rxv", 32'(ready), 32'(!e.lst));
      end else begin
        check("rx_unexpected", 32'(rx_valid), 32'(0));
      end
    end
  end

  task automatic set_mode(input spi_mode_t m, input logic lsb, input logic [DIV_W-1:0] d);
    cfg_cpol      = m.cpol;
    cfg_cpha      = m.cpha;
    cfg_lsb_first = lsb;
    cfg_div       = d;
    s_mode        = m;
    s_lsb         = lsb;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    check("ready_wait", 32'(ready), 32'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    check("idle_wait", 32'(busy), 32'(0));
  endtask

  // Issues one word; returns at the negedge after the accepting edge.
  task automatic do_word(input logic [DATA_W-1:0] tx, input logic lst, input logic [DATA_W-1:0] rx_exp);
    wait_ready();
    exp_rx.push_back('{data: rx_exp, lst: lst});
    exp_mosi.push_back(tx);
    tx_data = tx;
    last    = lst;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic check_edges(input string tag, input int spacing);
    int gaps;
    gaps = 0;
    check({tag, "_count"}, 32'(edge_t.size()), 32'(2 * DATA_W));
    for (int i = 1; i < edge_t.size(); i++)
      if (edge_t[i] - edge_t[i-1] != time'(spacing * 10)) gaps++;
    check({tag, "_bad_gaps"}, 32'(gaps), 32'(0));
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    spi_mode_t modes[3];
    int base_rxv, base_words;
    modes = '{MODE1, MODE2, MODE3};

    rst_n = 1'b0; start = 1'b0; last = 1'b0; tx_data = '0; miso = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = 16'd2; cs_sel = 1'b0;
    s_mode = MODE0; s_lsb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck",      32'(sck),      32'(0));
    check("rst_mosi",     32'(mosi),     32'(0));
    check("rst_cs_n",     32'(cs_n),     32'(2'b11));
    check("rst_rx_data",  32'(rx_data),  32'(0));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_ready",    32'(ready),    32'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, div 2, single word with last.
    set_mode(MODE0, 1'b0, 16'd2);
    edge_t.delete();
    slave_q.push_back(8'h3C);
    do_word(8'hA5, 1'b1, 8'h3C);
    check("m0_cs_n_active", 32'(cs_n), 32'(2'b10));
    check("m0_setup_mosi", 32'(mosi), 32'(1));
    wait_idle();
    check_edges("m0_edges", 2);
    if (edge_t.size() == 2 * DATA_W) begin
      check("m0_cs_lead",  32'((edge_t[0] - t_cs0_fall) / 10), 32'(2));
      check("m0_cs_trail", 32'((t_cs0_rise - edge_t[2*DATA_W-1]) / 10), 32'(2));
    end

    // Modes 1..3 with echoed 0x81.
    foreach (modes[k]) begin
      set_mode(modes[k], 1'b0, 16'd3);
      check("idle_sck_cpol", 32'(sck), 32'(modes[k].cpol));
      slave_q.push_back(8'h81);
      do_word(8'h81, 1'b1, 8'h81);
      check("setup_mosi_cpha", 32'(mosi), 32'(!modes[k].cpha));
      wait_idle();
      check("post_sck_cpol", 32'(sck), 32'(modes[k].cpol));
    end

    // LSB-first.
    set_mode(MODE0, 1'b1, 16'd2);
    slave_q.push_back(8'h80);
    do_word(8'h01, 1'b1, 8'h80);
    check("lsb_first_bit", 32'(mosi), 32'(1));
    wait_idle();

    // Three-word transaction on cs_sel = 1.
    set_mode(MODE0, 1'b0, 16'd2);
    cs_sel = 1'b1;
    cs1_rise = 0; cs0_fall = 0; base_rxv = rxv_cnt;
    slave_q.push_back(8'hE1); slave_q.push_back(8'hE2); slave_q.push_back(8'hE3);
    do_word(8'h11, 1'b0, 8'hE1);
    check("mw_cs_n_active", 32'(cs_n), 32'(2'b01));
    do_word(8'h22, 1'b0, 8'hE2);
    do_word(8'h33, 1'b1, 8'hE3);
    wait_idle();
    check("mw_rx_valid_count", 32'(rxv_cnt - base_rxv), 32'(3));
    check("mw_cs1_rises", 32'(cs1_rise), 32'(1));
    check("mw_cs0_falls", 32'(cs0_fall), 32'(0));
    cs_sel = 1'b0;

    // div = 0 behaves as div = 1.
    set_mode(MODE0, 1'b0, 16'd0);
    edge_t.delete();
    slave_q.push_back(8'h5A);
    do_word(8'hC3, 1'b1, 8'h5A);
    wait_idle();
    check_edges("div0_edges", 1);

    // start during SHIFT is ignored.
    set_mode(MODE0, 1'b0, 16'd2);
    base_rxv = rxv_cnt; base_words = s_words;
    slave_q.push_back(8'h66);
    do_word(8'h99, 1'b1, 8'h66);
    repeat (8) @(negedge clk);
    check("shift_ready_low", 32'(ready), 32'(0));
    tx_data = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("busy_start_rxv", 32'(rxv_cnt - base_rxv), 32'(1));
    check("busy_start_words", 32'(s_words - base_words), 32'(1));

    // Reset mid-word, with CPOL=1 so the sck reset value is distinguishable.
    set_mode(MODE2, 1'b0, 16'd2);
    slave_q.push_back(8'h77);
    do_word(8'h44, 1'b1, 8'h77);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n",  32'(cs_n),  32'(2'b11));
    check("midrst_sck",   32'(sck),   32'(0));
    check("midrst_busy",  32'(busy),  32'(0));
    check("midrst_ready", 32'(ready), 32'(1));
    exp_rx.delete(); exp_mosi.delete(); slave_q.delete();
    base_rxv = rxv_cnt;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_rxv", 32'(rxv_cnt - base_rxv), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
